// File: rtl/weight_feeder_pkg.sv
// Shared NPU definitions for the weight feeder: kernel geometry defaults,
// weight width, shift-counter width and the feeder state encoding.
package weight_feeder_pkg;

   localparam int unsigned KH_DEFAULT = 3;   // kernel rows, bytes per column word
   localparam int unsigned KW_DEFAULT = 3;   // kernel columns, words per kernel
   localparam int unsigned WEIGHT_W   = 8;   // one weight byte
   localparam int unsigned CNT_W      = 8;   // rotation counter width

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFetch,
      StDrain,
      StStream
   } fsm_state_e;

endpackage

// File: rtl/weight_feeder.sv
// Weight feeder: clears the circular weight register, fetches one kernel
// (K_W column words) from weight memory into it, then serves a fixed number
// of rotation requests from the compute side before returning to idle.
module weight_feeder
   import weight_feeder_pkg::*;
#(
   parameter int unsigned K_H    = KH_DEFAULT,
   parameter int unsigned K_W    = KW_DEFAULT,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      num_shifts,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [WEIGHT_W*K_H-1:0] mem_rdata,
   output logic                  w_clear,
   output logic                  w_load_en,
   output logic [WEIGHT_W-1:0]   w_in_data [K_H],
   output logic                  w_shift,
   input  logic                  shift_req,
   output logic                  weights_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned IdxW = $clog2(K_W + 1);

   fsm_state_e        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [IdxW-1:0]   idx_q, idx_d;     // column index of the current read
   logic [CNT_W-1:0]  cnt_q, cnt_d;     // rotations served so far
   logic              load_q, load_d;   // read issued last cycle -> load now
   logic              shift_q, shift_d;
   logic              clr_q, clr_d;     // clear pulse following an abort
   logic              done_q, done_d;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= '0;
         num_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         shift_q <= 1'b0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         num_q   <= num_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         shift_q <= shift_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; abort overrides every transition
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      num_d   = num_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      shift_d = 1'b0;
      clr_d   = 1'b0;
      done_d  = 1'b0;
      // An aborted read must never turn into a load
      load_d  = mem_rd_en && !abort;

      if (abort) begin
         state_d = StIdle;
         clr_d   = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StClear;
                  base_d  = base_addr;
                  num_d   = num_shifts;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
            StClear: begin
               state_d = (K_W > 1) ? StFetch : StDrain;
               idx_d   = IdxW'(1);
            end
            StFetch: begin
               if (idx_q == IdxW'(K_W - 1)) begin
                  state_d = StDrain;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            StDrain: begin
               state_d = StStream;
               // Zero rotations: completion coincides with the first stream cycle
               done_d  = (num_q == '0);
            end
            StStream: begin
               if (cnt_q == num_q) begin
                  state_d = StIdle;
                  done_d  = (num_q != '0);
               end else if (shift_req) begin
                  shift_d = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Moore outputs decoded from the registered state
   always_comb begin
      mem_rd_en     = (state_q == StClear) || (state_q == StFetch);
      mem_addr      = mem_rd_en ? base_q + ADDR_W'(idx_q) : '0;
      w_clear       = (state_q == StClear) || clr_q;
      w_load_en     = load_q;
      w_shift       = shift_q;
      weights_valid = (state_q == StStream);
      busy          = (state_q != StIdle);
      done          = done_q;
   end

   // Column bytes pass straight from memory to the weight register
   always_comb begin
      for (int r = 0; r < K_H; r++) begin
         w_in_data[r] = mem_rdata[WEIGHT_W*r +: WEIGHT_W];
      end
   end

endmodule

// File: doc/weight_feeder.md
WEIGHT_FEEDER -- requirements
Module: weight_feeder

Interface
REQ-001 SHALL have parameter K_H, default 3, meaning kernel rows (bytes per column word).
REQ-002 SHALL have parameter K_W, default 3, meaning kernel columns (words per kernel).
REQ-003 SHALL have parameter ADDR_W, default 10, meaning weight-memory address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port start, input, 1, kernel-load request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1, return to IDLE from any state.
REQ-008 SHALL have port base_addr, input, ADDR_W, address of kernel column 0, captured on start.
REQ-009 SHALL have port num_shifts, input, 8, rotations to serve, captured on start.
REQ-010 SHALL have port mem_rd_en, output, 1, weight-memory read strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_W, read address.
REQ-012 SHALL have port mem_rdata, input, 8*K_H, column word; valid exactly 1 cycle after mem_rd_en; byte r = bits [8r+7:8r].
REQ-013 SHALL have port w_clear, output, 1, clear to the circular weight register (cir_reg_w).
REQ-014 SHALL have port w_load_en, output, 1, column-load strobe to cir_reg_w.
REQ-015 SHALL have port w_in_data, output, 8 x [0:K_H-1], column bytes to cir_reg_w.
REQ-016 SHALL have port w_shift, output, 1, rotate strobe to cir_reg_w.
REQ-017 SHALL have port shift_req, input, 1, compute side requests one rotation.
REQ-018 SHALL have port weights_valid, output, 1, high while cir_reg_w holds a complete kernel (STREAM).
REQ-019 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-020 SHALL have port done, output, 1, one-cycle pulse on completion.

Function
REQ-021 SHALL implement states IDLE, CLEAR, FETCH, DRAIN, STREAM.
REQ-022 IDLE: start=1 at edge E0 -> CLEAR in cycle C1; base_addr/num_shifts latched.
REQ-023 CLEAR (1 cycle, C1): w_clear=1, mem_rd_en=1, mem_addr=base.
REQ-024 FETCH (C2..C_K_W): mem_rd_en=1, mem_addr=base+i for i=1..K_W-1, ascending; then DRAIN (1 cycle).
REQ-025 w_load_en SHALL be mem_rd_en delayed one cycle; w_in_data[r] SHALL be mem_rdata byte r combinationally; loads occupy C2..C_(K_W+1).
REQ-026 STREAM SHALL be entered in C_(K_W+2) (C5 for K_W=3) with weights_valid=1; cir_reg_w then presents column K_W-1, and each w_shift advances the presented column by +1 mod K_W.
REQ-027 In STREAM, shift_req=1 at an edge SHALL give w_shift=1 the next cycle and increment an 8-bit shift counter; back-to-back requests SHALL give back-to-back shifts.
REQ-028 When counter reaches num_shifts: next cycle done=1, state IDLE, weights_valid=0; further shift_req ignored.
REQ-029 num_shifts=0: done SHALL pulse in the first STREAM cycle, with no w_shift, then IDLE.
REQ-030 shift_req outside STREAM SHALL be ignored (no w_shift, no count).
REQ-031 start while busy SHALL be ignored.
REQ-032 abort SHALL have priority over all transitions: next cycle IDLE, w_clear=1 for that cycle, no done, mem_rd_en=0; a read in flight SHALL NOT produce w_load_en.
REQ-033 mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-034 w_clear, w_load_en, w_shift SHALL be mutually exclusive in every cycle.

Reset
REQ-035 rst_n=0 at an edge SHALL force IDLE, counter 0, latched inputs 0, every output 0 (w_in_data follows mem_rdata but w_load_en=0), including mid-FETCH or mid-STREAM.

Structure
REQ-036 K_H/K_W defaults, the 8-bit weight width and the state enum SHALL reside in the shared NPU package.
REQ-037 No sub-module; single FSM plus address and shift counters.

Verification (bench instantiates cir_reg_w as consumer and a 1-cycle-latency memory model)
REQ-038 base=0x010, mem[0x10..0x12]={A,B,C}, num_shifts=3, shift_req each STREAM cycle -> clear C1, loads C2-C4, presented column sequence C,A,B,C, done one cycle after third shift.
REQ-039 num_shifts=0 -> weights_valid for exactly one cycle, done in C5, zero w_shift pulses.
REQ-040 base=0x3FF (ADDR_W=10) -> mem_addr sequence 0x3FF,0x000,0x001.
REQ-041 abort during FETCH (C2) -> IDLE next cycle, w_clear=1, no further w_load_en, no done; cir_reg_w reads all zero.
REQ-042 shift_req held in IDLE/FETCH, start while busy -> no w_shift, no restart; rst_n=0 mid-STREAM -> all outputs 0 next cycle.
